// File: rtl/reg_file_pkg.sv
// Shared datapath constants for the MIPS register file, decode and write-back.
package reg_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file.sv
// MIPS general-purpose register file: 31 writable registers, r0 hardwired to zero,
// two combinational read ports with same-cycle write-through bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] regWriteData,
  input  logic [ADDR_WIDTH-1:0] regWriteAddr,
  input  logic                  regWriteEn,
  input  logic [ADDR_WIDTH-1:0] RsAddr,
  input  logic [ADDR_WIDTH-1:0] RtAddr,
  output logic [DATA_WIDTH-1:0] RsData,
  output logic [DATA_WIDTH-1:0] RtData
);

  localparam int                    NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO  = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [1:NREGS-1];
  logic                  write_ok;

  // A write only lands outside reset and never on r0; bypass uses the same qualifier.
  assign write_ok = reset && regWriteEn && (regWriteAddr != ZERO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[regWriteAddr] <= regWriteData;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if (addr == ZERO)
      return '0;
    else if (write_ok && (addr == regWriteAddr))
      return regWriteData;
    else
      return regs[addr];
  endfunction

  always_comb begin
    RsData = read_port(RsAddr);
    RtData = read_port(RtAddr);
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues hand-computed read values,
// a negedge monitor pops and compares them against both read ports.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] regWriteData;
  logic [4:0]  regWriteAddr;
  logic        regWriteEn;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic [31:0] RsData;
  logic [31:0] RtData;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    string       name;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .regWriteData (regWriteData),
    .regWriteAddr (regWriteAddr),
    .regWriteEn   (regWriteEn),
    .RsAddr       (RsAddr),
    .RtAddr       (RtAddr),
    .RsData       (RsData),
    .RtData       (RtData)
  );

  task automatic drive(input logic rst, input logic en, input logic [31:0] d,
                       input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    reset        = rst;
    regWriteEn   = en;
    regWriteData = d;
    regWriteAddr = wa;
    RsAddr       = ra;
    RtAddr       = rb;
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [31:0] d,
                     input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [31:0] ers, input logic [31:0] ert, input string name);
    exp_t e;
    drive(rst, en, d, wa, ra, rb);
    e.rs   = ers;
    e.rt   = ert;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: inputs settle 1ns after posedge, outputs are sampled at the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (RsData !== e.rs || RtData !== e.rt) begin
          errors++;
          $display("FAIL %s: RsAddr=%0d RsData=%h need %h, RtAddr=%0d RtData=%h need %h",
                   e.name, RsAddr, RsData, e.rs, RtAddr, RtData, e.rt);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; regWriteEn = 1'b0; regWriteData = '0;
    regWriteAddr = '0; RsAddr = '0; RtAddr = '0;

    // Initial reset, contents before the first edge are don't-care.
    drive(1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'(i), 5'(31 - i), 32'h0, 32'h0, "post_reset_zero");

    // Sweep: Rs sees the bypass, Rt sees the register written in the previous cycle.
    for (int a = 30; a >= 1; a--)
      cyc(1'b1, 1'b1, 32'h55AA_AA55, 5'(a), 5'(a), 5'(a + 1),
          32'h55AA_AA55, (a == 30) ? 32'h0 : 32'h55AA_AA55, "sweep");
    cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'd1, 5'd30, 32'h55AA_AA55, 32'h55AA_AA55, "sweep_hold");

    // Reset with write enabled: old contents visible pre-edge, no bypass, write dropped.
    cyc(1'b0, 1'b1, 32'h1111_1111, 5'd7, 5'd7, 5'd3, 32'h55AA_AA55, 32'h55AA_AA55, "reset_no_bypass");
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_clear");

    // Register 0 is never written nor bypassed.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, "r0_write_cycle");
    cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, "r0_after");

    // Dual port.
    cyc(1'b1, 1'b1, 32'h1234_5678, 5'd5, 5'd5, 5'd17, 32'h1234_5678, 32'h0, "dual_w5");
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 5'd17, 5'd5, 5'd17, 32'h1234_5678, 32'hDEAD_BEEF, "dual_w17");
    cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'd5, 5'd17, 32'h1234_5678, 32'hDEAD_BEEF, "dual_read");
    cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'd17, 5'd17, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "dual_same");

    // Enable low: r9 keeps its prior value and is not bypassed.
    cyc(1'b1, 1'b1, 32'hA5A5_0009, 5'd9, 5'd9, 5'd0, 32'hA5A5_0009, 32'h0, "en_prior_w9");
    cyc(1'b1, 1'b0, 32'hCAFE_F00D, 5'd9, 5'd9, 5'd9, 32'hA5A5_0009, 32'hA5A5_0009, "en_low_cycle");
    cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'd9, 5'd9, 32'hA5A5_0009, 32'hA5A5_0009, "en_low_after");

    // Bypass suppressed during reset; Rt shows r9 pre-edge, both clear afterwards.
    cyc(1'b0, 1'b1, 32'h7777_7777, 5'd3, 5'd3, 5'd9, 32'h0, 32'hA5A5_0009, "reset_bypass_cycle");
    cyc(1'b1, 1'b0, 32'h0, 5'd0, 5'd3, 5'd9, 32'h0, 32'h0, "reset_bypass_after");

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
